// File: rtl/logic_processor_n.sv
// Bit-serial two-register logic processor: WIDTH-bit A/B combined STEP bits per cycle.
// Optional LOGIC_PROC_EXEC_COUNT_EN adds a 16-bit completed-operation counter output.
module logic_processor_n #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_a_i,
    input  logic             load_b_i,
    input  logic             execute_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic [2:0]       f_i,
    input  logic [1:0]       r_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic             busy_o,
`ifdef LOGIC_PROC_EXEC_COUNT_EN
    output logic [15:0]      exec_count_o,
`endif
    output logic             done_o
);

    localparam int unsigned N    = WIDTH / STEP;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || STEP < 1 || STEP > WIDTH || (WIDTH % STEP) != 0) begin : g_bad_param
            $error("logic_processor_n: illegal WIDTH/STEP combination");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [2:0]       f_q;
    logic [1:0]       r_q;
    logic             busy_q, done_q;
`ifdef LOGIC_PROC_EXEC_COUNT_EN
    logic [15:0]      exec_cnt_q;
`endif

    logic [STEP-1:0]  a_lo, b_lo, func, a_new, b_new;
    logic [WIDTH-1:0] a_shift, b_shift;
    logic             last_shift;

    always_comb begin
        a_lo = a_q[STEP-1:0];
        b_lo = b_q[STEP-1:0];
        unique case (f_q[1:0])
            2'b00:   func = a_lo & b_lo;
            2'b01:   func = a_lo | b_lo;
            2'b10:   func = a_lo ^ b_lo;
            default: func = '1;
        endcase
        // Upper half of the function table is the inverse of the lower half.
        if (f_q[2]) func = ~func;
        unique case (r_q)
            2'b00:   begin a_new = a_lo; b_new = b_lo; end
            2'b01:   begin a_new = a_lo; b_new = func; end
            2'b10:   begin a_new = func; b_new = b_lo; end
            default: begin a_new = b_lo; b_new = a_lo; end
        endcase
        a_shift    = (a_q >> STEP) | (WIDTH'(a_new) << (WIDTH - STEP));
        b_shift    = (b_q >> STEP) | (WIDTH'(b_new) << (WIDTH - STEP));
        last_shift = (cnt_q == CntW'(N - 1));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            f_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef LOGIC_PROC_EXEC_COUNT_EN
            exec_cnt_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (execute_i) begin
                        f_q     <= f_i;
                        r_q     <= r_i;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StShift;
                    end else begin
                        if (load_a_i) a_q <= din_i;
                        if (load_b_i) b_q <= din_i;
                    end
                end
                StShift: begin
                    a_q   <= a_shift;
                    b_q   <= b_shift;
                    cnt_q <= cnt_q + CntW'(1);
                    if (last_shift) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StHold;
`ifdef LOGIC_PROC_EXEC_COUNT_EN
                        exec_cnt_q <= exec_cnt_q + 16'd1;
`endif
                    end
                end
                StHold: begin
                    // Level-held Execute must drop before another operation can start.
                    if (!execute_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign a_o    = a_q;
    assign b_o    = b_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
`ifdef LOGIC_PROC_EXEC_COUNT_EN
    assign exec_count_o = exec_cnt_q;
`endif

endmodule

// File: tb/tb_logic_processor_n.sv
// Scoreboard bench for logic_processor_n: an 8/1 instance plus 16/4 and 16/16 instances.
// Each Done pulse is popped against a queue of expected A/B/busy-length entries.
module tb_logic_processor_n;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        la = 0, lb = 0, ex = 0;
    logic [7:0]  din = '0;
    logic [2:0]  f = '0;
    logic [1:0]  r = '0;
    logic [7:0]  a8, b8;
    logic        busy8, done8;
    logic        wla = 0, wlb = 0, wex = 0;
    logic [15:0] wdin = '0;
    logic [2:0]  wf = '0;
    logic [1:0]  wr = '0;
    logic [15:0] a4, b4, a16, b16;
    logic        busy4, done4, busy16, done16;
    logic [15:0] cnt8, cnt4, cnt16;

    exp_t q8[$], q4[$], q16[$];
    int   checks = 0, errors = 0;
    int   bc8 = 0, bc4 = 0, bc16 = 0;
    int   ops8 = 0;

    always #5 clk = ~clk;

    logic_processor_n #(.WIDTH(8), .STEP(1)) dut8 (
        .clk_i(clk), .rst_ni(rst_n), .load_a_i(la), .load_b_i(lb), .execute_i(ex),
        .din_i(din), .f_i(f), .r_i(r), .a_o(a8), .b_o(b8), .busy_o(busy8),
`ifdef LOGIC_PROC_EXEC_COUNT_EN
        .exec_count_o(cnt8),
`endif
        .done_o(done8)
    );

    logic_processor_n #(.WIDTH(16), .STEP(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .load_a_i(wla), .load_b_i(wlb), .execute_i(wex),
        .din_i(wdin), .f_i(wf), .r_i(wr), .a_o(a4), .b_o(b4), .busy_o(busy4),
`ifdef LOGIC_PROC_EXEC_COUNT_EN
        .exec_count_o(cnt4),
`endif
        .done_o(done4)
    );

    logic_processor_n #(.WIDTH(16), .STEP(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_n), .load_a_i(wla), .load_b_i(wlb), .execute_i(wex),
        .din_i(wdin), .f_i(wf), .r_i(wr), .a_o(a16), .b_o(b16), .busy_o(busy16),
`ifdef LOGIC_PROC_EXEC_COUNT_EN
        .exec_count_o(cnt16),
`endif
        .done_o(done16)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: Done pulse with no expected operation queued", name);
    endtask

    // Monitor: counts Busy cycles and checks results whenever Done is presented.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            bc8 = 0; bc4 = 0; bc16 = 0;
        end else begin
            if (busy8) bc8++;
            if (busy4) bc4++;
            if (busy16) bc16++;
            if (done8) begin
                if (q8.size() == 0) unexpected("done8");
                else begin
                    e = q8.pop_front();
                    chk("w8 A", {24'h0, a8}, {16'h0, e.a});
                    chk("w8 B", {24'h0, b8}, {16'h0, e.b});
                    chk("w8 busy cycles", bc8, e.busy);
                end
                bc8 = 0;
            end
            if (done4) begin
                if (q4.size() == 0) unexpected("done4");
                else begin
                    e = q4.pop_front();
                    chk("s4 A", {16'h0, a4}, {16'h0, e.a});
                    chk("s4 B", {16'h0, b4}, {16'h0, e.b});
                    chk("s4 busy cycles", bc4, e.busy);
                end
                bc4 = 0;
            end
            if (done16) begin
                if (q16.size() == 0) unexpected("done16");
                else begin
                    e = q16.pop_front();
                    chk("s16 A", {16'h0, a16}, {16'h0, e.a});
                    chk("s16 B", {16'h0, b16}, {16'h0, e.b});
                    chk("s16 busy cycles", bc16, e.busy);
                end
                bc16 = 0;
            end
        end
    end

    task automatic load8(input logic [7:0] av, input logic [7:0] bv);
        @(posedge clk); #1 din = av; la = 1;
        @(posedge clk); #1 la = 0; din = bv; lb = 1;
        @(posedge clk); #1 lb = 0;
    endtask

    task automatic exec8(input logic [2:0] fv, input logic [1:0] rv,
                         input logic [7:0] ea, input logic [7:0] eb);
        q8.push_back('{a: {8'h0, ea}, b: {8'h0, eb}, busy: 8});
        ops8++;
        @(posedge clk); #1 f = fv; r = rv; ex = 1;
        @(posedge clk); #1 ex = 0;
        repeat (12) @(posedge clk);
    endtask

    task automatic wide_op(input logic [15:0] av, input logic [15:0] bv, input logic [2:0] fv,
                           input logic [1:0] rv, input logic [15:0] ea, input logic [15:0] eb);
        @(posedge clk); #1 wdin = av; wla = 1;
        @(posedge clk); #1 wla = 0; wdin = bv; wlb = 1;
        @(posedge clk); #1 wlb = 0;
        q4.push_back('{a: ea, b: eb, busy: 4});
        q16.push_back('{a: ea, b: eb, busy: 1});
        @(posedge clk); #1 wf = fv; wr = rv; wex = 1;
        @(posedge clk); #1 wex = 0;
        repeat (8) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset A", {24'h0, a8}, 32'h0);
        chk("reset B", {24'h0, b8}, 32'h0);
        chk("reset busy/done", {30'h0, busy8, done8}, 32'h0);
`ifdef LOGIC_PROC_EXEC_COUNT_EN
        chk("reset count", {16'h0, cnt8}, 32'h0);
`endif
        @(negedge clk); rst_n = 1;

        load8(8'h33, 8'h55);
        chk("load A", {24'h0, a8}, 32'h33);
        chk("load B", {24'h0, b8}, 32'h55);
        exec8(3'b000, 2'b10, 8'h11, 8'h55);

        load8(8'h33, 8'h55);
        exec8(3'b010, 2'b01, 8'h33, 8'h66);
        exec8(3'b000, 2'b11, 8'h66, 8'h33);

        // Execute held high: loads and F changes during SHIFT/HOLD must be ignored.
        load8(8'hF0, 8'hFF);
        q8.push_back('{a: 16'h0F, b: 16'hFF, busy: 8});
        ops8++;
        @(posedge clk); #1 f = 3'b100; r = 2'b10; ex = 1;
        repeat (3) @(posedge clk);
        #1 la = 1; din = 8'hAA; f = 3'b111;
        @(posedge clk); #1 la = 0;
        repeat (10) @(posedge clk);
        #1 la = 1; lb = 1;
        @(posedge clk); #1 la = 0; lb = 0;
        repeat (14) @(posedge clk);
        #1 ex = 0;
        repeat (3) @(posedge clk);
        #1 chk("held exec A", {24'h0, a8}, 32'h0F);
        chk("held exec B", {24'h0, b8}, 32'hFF);

        // Asynchronous reset during the 4th shift cycle.
        load8(8'h3C, 8'hC3);
        @(posedge clk); #1 f = 3'b000; r = 2'b10; ex = 1;
        @(posedge clk); #1 ex = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1 chk("mid-reset A", {24'h0, a8}, 32'h0);
        chk("mid-reset B", {24'h0, b8}, 32'h0);
        chk("mid-reset busy", {31'h0, busy8}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1;
        repeat (10) @(posedge clk);
        load8(8'h5A, 8'hA5);
        chk("post-reset A", {24'h0, a8}, 32'h5A);
        chk("post-reset B", {24'h0, b8}, 32'hA5);
        ops8 = 0;
        exec8(3'b110, 2'b01, 8'h5A, 8'h00);

        wide_op(16'h1234, 16'hFFFF, 3'b000, 2'b10, 16'h1234, 16'hFFFF);
        wide_op(16'h1234, 16'hFFFF, 3'b010, 2'b10, 16'hEDCB, 16'hFFFF);

`ifdef LOGIC_PROC_EXEC_COUNT_EN
        exec8(3'b000, 2'b00, 8'h5A, 8'h00);
        exec8(3'b111, 2'b00, 8'h5A, 8'h00);
        chk("exec count", {16'h0, cnt8}, ops8);
        force dut8.exec_cnt_q = 16'hFFFF;
        #1 release dut8.exec_cnt_q;
        exec8(3'b000, 2'b00, 8'h5A, 8'h00);
        chk("exec count wrap", {16'h0, cnt8}, 32'h0);
        chk("wide exec count", {16'h0, cnt4}, 32'h2);
`endif

        chk("pending w8", q8.size(), 0);
        chk("pending s4", q4.size(), 0);
        chk("pending s16", q16.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
